clock_mode_ctrl: RTL
====================

# clock_mode_ctrl

Mode controller for the digital clock/alarm datapath. It drives the enable and direction inputs of five external modulo up/down counters: seconds, minutes and hours for the time, plus minutes and hours for the alarm. It also runs a one-hot run/adjust state machine and generates a latched alarm-ring output. Counters sit outside this block; it sees their current values and asserts at most one step per counter per cycle.

## Interface
Parameters:
- `SEC_MOD`, 60, seconds counter modulus
- `MIN_MOD`, 60, minutes counter modulus
- `HOUR_MOD`, 24, hours counter modulus
- `SW`, 6, width of seconds/minutes value inputs
- `HW`, 5, width of hours value inputs
- `RING_SECS`, 30, ticks the alarm rings before self-clearing

Ports:
- `clk`, in, 1, clock
- `reset`, in, 1, reset; asynchronous, active-high
- `tick`, in, 1, one-cycle 1 Hz pulse
- `btn_c`, `btn_l`, `btn_r`, `btn_u`, `btn_d`, in, 1 each, debounced one-cycle button pulses
- `alarm_arm`, in, 1, level; alarm enabled
- `sec`, `min`, in, SW each, time counter values
- `hour`, in, HW, time counter value
- `alm_min`, in, SW, alarm counter value
- `alm_hour`, in, HW, alarm counter value
- `sec_en`, `min_en`, `hour_en`, `amin_en`, `ahour_en`, out, 1 each, counter enables
- `sec_ud`, `min_ud`, `hour_ud`, `amin_ud`, `ahour_ud`, out, 1 each, direction; 1 = up
- `mode_led`, out, 5, one-hot state indicator
- `alarm_ring`, out, 1, alarm active

## Operation
- States (one-hot, `mode_led` = state vector):
  - RUN = 00001
  - ADJ_HOUR = 00010
  - ADJ_MIN = 00100
  - ADJ_AHOUR = 01000
  - ADJ_AMIN = 10000
- State transitions:
  - `btn_c` in RUN goes to ADJ_HOUR.
  - `btn_c` in any ADJ state goes to RUN.
  - `btn_r` steps ADJ_HOUR → ADJ_MIN → ADJ_AHOUR → ADJ_AMIN → ADJ_HOUR.
  - `btn_l` steps the same ring in reverse.
  - `btn_l`/`btn_r` are ignored in RUN.
- RUN mode:
  - `sec_en` = `tick`.
  - `min_en` = `tick` & (`sec` == SEC_MOD-1).
  - `hour_en` = `min_en` & (`min` == MIN_MOD-1).
  - All `*_ud` = 1.
  - Alarm enables = 0.
  - `btn_u`/`btn_d` are ignored.
- ADJ states:
  - `tick` is ignored and all time counters are frozen, including seconds.
  - Only the selected counter gets an enable: `en` = `btn_u` XOR `btn_d`, `ud` = `btn_u`.
  - `btn_u` & `btn_d` together produce no step.
  - No carry between fields; wrap-around is left to the counters.
- Default for every unselected output: `en` = 0, `ud` = 1.
- Button priority within one cycle: `btn_c` > `btn_l`/`btn_r` > `btn_u`/`btn_d`. A lower-priority pulse coinciding with a higher one is discarded. `btn_l` & `btn_r` together: no move.
- Alarm set condition: state RUN, `alarm_arm`, `tick`, `sec` == 0, `hour` == `alm_hour`, `min` == `alm_min`. This happens once per match minute.
- While ringing:
  - An internal ring counter counts ticks; `alarm_ring` clears after RING_SECS ticks.
  - Any button pulse clears it immediately, and that pulse is consumed (no state change, no step).
  - Deasserting `alarm_arm` clears it.
  - Clear beats set in the same cycle.

## Timing
- Reset values:
  - State RUN, `mode_led` = 00001.
  - `alarm_ring` = 0, ring counter = 0.
  - All `*_en` = 0, all `*_ud` = 1.
- `*_en`/`*_ud` are combinational from the registered state plus the current pulses. The counter steps on the same edge that samples the pulse, so effective latency is 1 cycle.
- State, `alarm_ring` and the ring counter are registered. A `btn_c` at edge N makes `mode_led` change after edge N. Enables in cycle N still decode the old state.
- `alarm_ring` rises the cycle after the set condition.
- Reset mid-ring or mid-adjust forces RUN and clears the ring immediately (asynchronous).
- At most one enable per counter per cycle.
- Carries use pre-increment counter values sampled in the tick cycle.

## Structure
- A shared package `clock_pkg` holds:
  - State localparams `ST_RUN`…`ST_AMIN`.
  - Default moduli 60/60/24.
  - Widths SW/HW.
- One natural sub-module, `alarm_ringer`, owns the set/clear logic and the RING_SECS tick counter (width clog2(RING_SECS+1)). The FSM and enable decode stay in the top level.

## Test plan
- Reset, then `tick` with `sec`=59, `min`=59, `hour`=23 → `sec_en`=`min_en`=`hour_en`=1, all `ud`=1, `mode_led`=00001.
- `btn_c`, then `btn_r` twice, then `btn_u` → `mode_led` 00010 → 00100 → 01000. `ahour_en`=1 with `ahour_ud`=1 for exactly the `btn_u` cycle. `tick` in this state gives `sec_en`=0.
- In ADJ_MIN: `btn_d` → `min_en`=1, `min_ud`=0. `btn_u`+`btn_d` together → no enables. `btn_c`+`btn_u` together → RUN, no step.
- `alarm_arm`=1, `alm_hour`=7, `alm_min`=30, time 07:30:00, `tick` → `alarm_ring`=1 next cycle. After 30 further ticks → 0.
- Ringing, then `btn_r` pulse → `alarm_ring`=0 next cycle, `mode_led` unchanged. Set and clear in the same cycle → stays 0.
- Assert `reset` asynchronously while in ADJ_AMIN with `alarm_ring`=1 → RUN and `alarm_ring`=0 without a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, default moduli and widths for the clock/alarm controller
package clock_pkg;

    typedef enum logic [4:0] {
        ST_RUN   = 5'b00001,
        ST_HOUR  = 5'b00010,
        ST_MIN   = 5'b00100,
        ST_AHOUR = 5'b01000,
        ST_AMIN  = 5'b10000
    } state_t;

    localparam int DEF_SEC_MOD  = 60;
    localparam int DEF_MIN_MOD  = 60;
    localparam int DEF_HOUR_MOD = 24;
    localparam int DEF_SW       = 6;
    localparam int DEF_HW       = 5;

    // Rotate within the four adjust states (bits 4:1); fwd walks HOUR->MIN->AHOUR->AMIN->HOUR
    function automatic state_t ring_next(input state_t s, input logic fwd);
        return fwd ? state_t'({s[3:1], s[4], 1'b0}) : state_t'({s[1], s[4:2], 1'b0});
    endfunction

endpackage

// File: rtl/alarm_ringer.sv
// alarm_ringer: latches the alarm on a matching RUN tick and clears it on timeout, button or disarm
module alarm_ringer #(
    parameter int RING_SECS = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic tick_i,
    input  logic btn_i,
    input  logic arm_i,
    input  logic match_i,
    output logic ring_o
);

    localparam int CW = $clog2(RING_SECS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ring_q, ring_d;
    logic          set, done, clr;

    always_comb begin
        set    = run_i & arm_i & tick_i & match_i;
        done   = ring_q & tick_i & (cnt_q == CW'(RING_SECS - 1));
        clr    = btn_i | ~arm_i | done;
        ring_d = clr ? 1'b0 : (set | ring_q);
        // counter restarts on every fresh set and idles at zero when not ringing
        cnt_d  = (ring_d & ring_q) ? (tick_i ? cnt_q + CW'(1) : cnt_q) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ring_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ring_q <= ring_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: run/adjust mode FSM and counter enable/direction decode for the clock/alarm datapath
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int SEC_MOD   = DEF_SEC_MOD,
    parameter int MIN_MOD   = DEF_MIN_MOD,
    parameter int HOUR_MOD  = DEF_HOUR_MOD,
    parameter int SW        = DEF_SW,
    parameter int HW        = DEF_HW,
    parameter int RING_SECS = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          btn_c,
    input  logic          btn_l,
    input  logic          btn_r,
    input  logic          btn_u,
    input  logic          btn_d,
    input  logic          alarm_arm,
    input  logic [SW-1:0] sec,
    input  logic [SW-1:0] min,
    input  logic [HW-1:0] hour,
    input  logic [SW-1:0] alm_min,
    input  logic [HW-1:0] alm_hour,
    output logic          sec_en,
    output logic          min_en,
    output logic          hour_en,
    output logic          amin_en,
    output logic          ahour_en,
    output logic          sec_ud,
    output logic          min_ud,
    output logic          hour_ud,
    output logic          amin_ud,
    output logic          ahour_ud,
    output logic [4:0]    mode_led,
    output logic          alarm_ring
);

    state_t state_q, state_d;
    logic   run, act, c, mv, step, dn, match;

    assign run   = (state_q == ST_RUN);
    // out-of-range hours never come from the counter, so they never raise the alarm
    assign match = (sec == '0) & (min == alm_min) & (hour == alm_hour) & (int'(hour) < HOUR_MOD);

    always_comb begin
        // a ringing alarm swallows every button pulse
        act      = ~reset & ~alarm_ring;
        c        = act & btn_c;
        mv       = act & ~btn_c & (btn_l ^ btn_r);
        step     = act & ~btn_c & ~btn_l & ~btn_r & (btn_u ^ btn_d);
        dn       = step & btn_d;
        state_d  = c ? (run ? ST_HOUR : ST_RUN) : (mv & ~run) ? ring_next(state_q, btn_r) : state_q;
        sec_en   = ~reset & run & tick;
        min_en   = run ? (sec_en & (sec == SW'(SEC_MOD - 1))) : (step & (state_q == ST_MIN));
        hour_en  = run ? (min_en & (min == SW'(MIN_MOD - 1))) : (step & (state_q == ST_HOUR));
        amin_en  = step & (state_q == ST_AMIN);
        ahour_en = step & (state_q == ST_AHOUR);
        sec_ud   = 1'b1;
        min_ud   = ~(dn & (state_q == ST_MIN));
        hour_ud  = ~(dn & (state_q == ST_HOUR));
        amin_ud  = ~(dn & (state_q == ST_AMIN));
        ahour_ud = ~(dn & (state_q == ST_AHOUR));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    assign mode_led = state_q;

    alarm_ringer #(.RING_SECS(RING_SECS)) u_ringer (
        .clk    (clk),
        .reset  (reset),
        .run_i  (run),
        .tick_i (tick),
        .btn_i  (|{btn_c, btn_l, btn_r, btn_u, btn_d}),
        .arm_i  (alarm_arm),
        .match_i(match),
        .ring_o (alarm_ring)
    );

endmodule
